// File: rtl/sextium_io_pkg.sv
// Shared definitions for the Sextium III I/O bridge.
//   IO_WIDTH      : default I/O word width (matches core io_bus_*)
//   IO_DEPTH_LOG2 : default log2 of each FIFO depth
//   io_state_t    : core handshake FSM states
package sextium_io_pkg;

  localparam int unsigned IO_WIDTH      = 16;
  localparam int unsigned IO_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } io_state_t;

endpackage

// File: rtl/sextium_io_bridge_if.sv
// Bus bundle between the Sextium core I/O port, the external RX/TX streams and the bridge.
//   core side  : io_read, io_write, io_bus_out -> bridge ; io_bus_in, ioack <- bridge
//   rx stream  : rx_data, rx_valid -> bridge ; rx_ready <- bridge
//   tx stream  : tx_ready -> bridge ; tx_data, tx_valid <- bridge
//   status     : rx_count, tx_count, proto_err <- bridge
// modport slave is the bridge view, modport master the environment view.
interface sextium_io_bridge_if
  import sextium_io_pkg::*;
#(
  parameter int unsigned WIDTH      = IO_WIDTH,
  parameter int unsigned DEPTH_LOG2 = IO_DEPTH_LOG2
);

  logic                  io_read;
  logic                  io_write;
  logic [WIDTH-1:0]      io_bus_out;
  logic [WIDTH-1:0]      io_bus_in;
  logic                  ioack;
  logic [WIDTH-1:0]      rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [WIDTH-1:0]      tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DEPTH_LOG2:0]   rx_count;
  logic [DEPTH_LOG2:0]   tx_count;
  logic                  proto_err;

  modport slave (
    input  io_read, io_write, io_bus_out, rx_data, rx_valid, tx_ready,
    output io_bus_in, ioack, rx_ready, tx_data, tx_valid, rx_count, tx_count, proto_err
  );

  modport master (
    output io_read, io_write, io_bus_out, rx_data, rx_valid, tx_ready,
    input  io_bus_in, ioack, rx_ready, tx_data, tx_valid, rx_count, tx_count, proto_err
  );

endinterface

// File: rtl/sextium_sync_fifo.sv
// Synchronous show-ahead FIFO, 2^DEPTH_LOG2 entries.
//   clk, rst_n     : clock, synchronous active-low reset (empties the FIFO)
//   push, din      : write request/data; ignored while full
//   pop            : read request; ignored while empty
//   full, empty    : status decoded from the registered count
//   count          : occupancy 0..2^DEPTH_LOG2
//   head           : oldest entry (valid while !empty)
module sextium_sync_fifo #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  // Guard against overflow/underflow so counts saturate by construction.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == CW'(0));
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Storage: not reset, contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap modulo depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sextium_io_bridge.sv
// Sextium III I/O port bridge: terminates the core io_read/io_write/ioack
// handshake and buffers words in an RX FIFO (external stream -> core) and a
// TX FIFO (core -> external stream).
//   clock      : sole clock
//   reset      : synchronous active-low reset
//   bus        : sextium_io_bridge_if.slave (core port, rx/tx streams, status)
module sextium_io_bridge
  import sextium_io_pkg::*;
#(
  parameter int unsigned WIDTH      = IO_WIDTH,
  parameter int unsigned DEPTH_LOG2 = IO_DEPTH_LOG2
) (
  input  logic                clock,
  input  logic                reset,
  sextium_io_bridge_if.slave  bus
);

  io_state_t           r_state;
  logic [WIDTH-1:0]    r_bus_in;
  logic                r_ioack;
  logic                r_proto_err;
  logic                r_run;

  logic                w_rx_push;
  logic                w_rx_pop;
  logic                w_rx_full;
  logic                w_rx_empty;
  logic                w_rx_ready;
  logic [WIDTH-1:0]    w_rx_head;
  logic                w_tx_push;
  logic                w_tx_pop;
  logic                w_tx_full;
  logic                w_tx_empty;
  logic                w_tx_valid;

  // r_run holds rx_ready low while in reset and for the reset edge itself.
  assign w_rx_ready = r_run && !w_rx_full;
  assign w_rx_push  = bus.rx_valid && w_rx_ready;
  assign w_tx_valid = !w_tx_empty;
  assign w_tx_pop   = w_tx_valid && bus.tx_ready;

  // Core transfers are only taken in IDLE; a read always wins over a write.
  assign w_rx_pop  = (r_state == IDLE) && bus.io_read && !w_rx_empty;
  assign w_tx_push = (r_state == IDLE) && bus.io_write && !bus.io_read && !w_tx_full;

  sextium_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (bus.rx_data),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .count (bus.rx_count),
    .head  (w_rx_head)
  );

  sextium_sync_fifo #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (bus.io_bus_out),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .count (bus.tx_count),
    .head  (bus.tx_data)
  );

  // Handshake FSM: IDLE serves one request, ACK pulses ioack, RELEASE waits
  // for the core to drop its request so a held request completes only once.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_bus_in    <= '0;
      r_ioack     <= 1'b0;
      r_proto_err <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_ioack <= 1'b0;
      if (bus.io_read && bus.io_write) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_rx_pop) begin
            r_bus_in <= w_rx_head;
          end
          if (w_rx_pop || w_tx_push) begin
            r_ioack <= 1'b1;
            r_state <= ACK;
          end
        end
        ACK: begin
          r_state <= RELEASE;
        end
        RELEASE: begin
          if (!bus.io_read && !bus.io_write) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.io_bus_in = r_bus_in;
  assign bus.ioack     = r_ioack;
  assign bus.proto_err = r_proto_err;
  assign bus.rx_ready  = w_rx_ready;
  assign bus.tx_valid  = w_tx_valid;

endmodule

// File: tb/tb_sextium_io_bridge.sv
// Self-checking bench for sextium_io_bridge against queue-based FIFO models.
module tb_sextium_io_bridge;

  localparam int unsigned W     = 16;
  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] rxq[$];
  logic [W-1:0] txq[$];

  always #5 clock = ~clock;

  sextium_io_bridge_if #(.WIDTH(W), .DEPTH_LOG2(DL2)) bus ();

  sextium_io_bridge #(.WIDTH(W), .DEPTH_LOG2(DL2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one core read; returns the acked word and edges until ioack.
  task automatic core_read(output logic [W-1:0] data, output int lat, output bit ok);
    ok = 1'b0; lat = 0; data = '0;
    bus.io_read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      lat++;
      if (bus.ioack === 1'b1) begin
        ok = 1'b1;
        data = bus.io_bus_in;
        break;
      end
    end
    bus.io_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic core_write(input logic [W-1:0] data, output bit ok);
    ok = 1'b0;
    bus.io_write = 1'b1;
    bus.io_bus_out = data;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ioack === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.io_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic rx_push(input logic [W-1:0] data);
    bus.rx_valid = 1'b1;
    bus.rx_data = data;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = W'($urandom);
    repeat (3) tick();
    checks++; if (bus.ioack !== 1'b0) begin errors++; $display("FAIL reset_ioack: got %0h want 0", bus.ioack); end
    checks++; if (bus.io_bus_in !== '0) begin errors++; $display("FAIL reset_bus_in: got %0h want 0", bus.io_bus_in); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %0h want 0", bus.tx_valid); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %0h want 0", bus.rx_ready); end
    checks++; if (bus.rx_count !== '0) begin errors++; $display("FAIL reset_rx_count: got %0d want 0", bus.rx_count); end
    checks++; if (bus.tx_count !== '0) begin errors++; $display("FAIL reset_tx_count: got %0d want 0", bus.tx_count); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %0h want 0", bus.proto_err); end
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_rx_ready: got %0h want 1", bus.rx_ready); end
    checks++; if (bus.rx_count !== '0) begin errors++; $display("FAIL reset_release_rx_count: got %0d want 0", bus.rx_count); end
  endtask

  task automatic test_stalled_read();
    int acks;
    acks = 0;
    bus.io_read = 1'b1;
    repeat (5) begin
      tick();
      if (bus.ioack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL stall_no_ack: got %0d acks want 0", acks); end
    rx_push(16'hBEEF);
    checks++; if (bus.ioack !== 1'b0) begin errors++; $display("FAIL stall_no_bypass: ioack got %0h want 0", bus.ioack); end
    tick();
    checks++; if (bus.ioack !== 1'b1) begin errors++; $display("FAIL stall_ack: ioack got %0h want 1", bus.ioack); end
    checks++; if (bus.io_bus_in !== 16'hBEEF) begin errors++; $display("FAIL stall_data: got %0h want beef", bus.io_bus_in); end
    checks++; if (bus.rx_count !== '0) begin errors++; $display("FAIL stall_rx_count: got %0d want 0", bus.rx_count); end
    bus.io_read = 1'b0;
    tick();
    checks++; if (bus.ioack !== 1'b0) begin errors++; $display("FAIL stall_ack_pulse: ioack got %0h want 0", bus.ioack); end
    tick();
  endtask

  task automatic test_held_write();
    int acks;
    acks = 0;
    bus.io_write = 1'b1;
    bus.io_bus_out = 16'h1234;
    repeat (6) begin
      tick();
      if (bus.ioack === 1'b1) acks++;
    end
    bus.io_write = 1'b0;
    repeat (2) begin
      tick();
      if (bus.ioack === 1'b1) acks++;
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL held_write_acks: got %0d want 1", acks); end
    checks++; if (bus.tx_count !== 5'd1) begin errors++; $display("FAIL held_write_tx_count: got %0d want 1", bus.tx_count); end
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL held_write_tx_valid: got %0h want 1", bus.tx_valid); end
    checks++; if (bus.tx_data !== 16'h1234) begin errors++; $display("FAIL held_write_tx_data: got %0h want 1234", bus.tx_data); end
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL held_write_drain: tx_valid got %0h want 0", bus.tx_valid); end
  endtask

  task automatic test_full_boundary();
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int lat;
    bit ok;
    int not_ready;
    not_ready = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (bus.rx_ready !== 1'b1) not_ready++;
      rx_push(W'(i));
      rxq.push_back(W'(i));
    end
    checks++; if (not_ready != 0) begin errors++; $display("FAIL full_fill_ready: %0d stalls want 0", not_ready); end
    checks++; if (bus.rx_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", bus.rx_count); end
    checks++; if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL full_rx_ready: got %0h want 0", bus.rx_ready); end
    rx_push(16'hDEAD);
    checks++; if (bus.rx_count !== 5'd16) begin errors++; $display("FAIL full_17th: count got %0d want 16", bus.rx_count); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      core_read(d, lat, ok);
      exp = rxq.pop_front();
      checks++; if (!ok || d !== exp) begin errors++; $display("FAIL full_read_%0d: got %0h ok=%0d want %0h", i, d, ok, exp); end
    end
    d = W'($urandom);
    rx_push(d);
    rxq.push_back(d);
    checks++; if (bus.rx_count !== 5'd1) begin errors++; $display("FAIL full_repush_count: got %0d want 1", bus.rx_count); end
    core_read(d, lat, ok);
    exp = rxq.pop_front();
    checks++; if (!ok || d !== exp || lat != 1) begin errors++; $display("FAIL full_repush_read: got %0h lat=%0d want %0h lat=1", d, lat, exp); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit ok;
    a = W'($urandom);
    b = W'($urandom);
    rx_push(a); rxq.push_back(a);
    rx_push(b); rxq.push_back(b);
    // Core pop and stream push on the same edge.
    bus.rx_data = W'($urandom);
    bus.rx_valid = 1'b1;
    bus.io_read = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    void'(rxq.pop_front());
    rxq.push_back(bus.rx_data);
    checks++; if (bus.ioack !== 1'b1 || bus.io_bus_in !== a) begin errors++; $display("FAIL b2b_rx_read: ack=%0h data=%0h want ack=1 data=%0h", bus.ioack, bus.io_bus_in, a); end
    checks++; if (bus.rx_count !== 5'd2) begin errors++; $display("FAIL b2b_rx_count: got %0d want 2", bus.rx_count); end
    bus.io_read = 1'b0;
    tick(); tick();
    // Core push and stream pop on the same edge.
    a = W'($urandom); b = W'($urandom);
    core_write(a, ok); txq.push_back(a);
    core_write(b, ok); txq.push_back(b);
    bus.io_bus_out = W'($urandom);
    bus.io_write = 1'b1;
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    void'(txq.pop_front());
    txq.push_back(bus.io_bus_out);
    checks++; if (bus.tx_count !== 5'd2 || bus.tx_data !== txq[0]) begin errors++; $display("FAIL b2b_tx: count=%0d head=%0h want 2 %0h", bus.tx_count, bus.tx_data, txq[0]); end
    bus.io_write = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int lat;
    bit ok;
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          d = W'($urandom);
          checks++; if (bus.rx_ready !== 1'(rxq.size() < int'(DEPTH))) begin errors++; $display("FAIL rand_rx_ready it%0d: got %0h want %0d", it, bus.rx_ready, rxq.size() < int'(DEPTH)); end
          rx_push(d);
          if (rxq.size() < int'(DEPTH)) rxq.push_back(d);
        end
        1: if (rxq.size() > 0) begin
          core_read(d, lat, ok);
          exp = rxq.pop_front();
          checks++; if (!ok || d !== exp) begin errors++; $display("FAIL rand_read it%0d: got %0h ok=%0d want %0h", it, d, ok, exp); end
        end
        2: if (txq.size() < int'(DEPTH)) begin
          d = W'($urandom);
          core_write(d, ok);
          txq.push_back(d);
          checks++; if (!ok) begin errors++; $display("FAIL rand_write it%0d: no ioack, want ack", it); end
        end
        default: if (txq.size() > 0) begin
          checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== txq[0]) begin errors++; $display("FAIL rand_tx it%0d: valid=%0h data=%0h want 1 %0h", it, bus.tx_valid, bus.tx_data, txq[0]); end
          bus.tx_ready = 1'b1;
          tick();
          bus.tx_ready = 1'b0;
          void'(txq.pop_front());
        end
      endcase
      checks++; if (bus.rx_count !== 5'(rxq.size()) || bus.tx_count !== 5'(txq.size())) begin errors++; $display("FAIL rand_counts it%0d: rx=%0d tx=%0d want %0d %0d", it, bus.rx_count, bus.tx_count, rxq.size(), txq.size()); end
    end
  endtask

  task automatic test_proto_err();
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int lat;
    bit ok;
    while (rxq.size() > 0) begin
      core_read(d, lat, ok);
      exp = rxq.pop_front();
      checks++; if (!ok || d !== exp) begin errors++; $display("FAIL proto_drain: got %0h want %0h", d, exp); end
    end
    rx_push(16'h00AA);
    bus.io_bus_out = W'($urandom);
    bus.io_write = 1'b1;
    core_read(d, lat, ok);
    bus.io_write = 1'b0;
    tick();
    checks++; if (!ok || d !== 16'h00AA) begin errors++; $display("FAIL proto_read: got %0h ok=%0d want aa", d, ok); end
    checks++; if (bus.tx_count !== 5'(txq.size())) begin errors++; $display("FAIL proto_tx_unchanged: got %0d want %0d", bus.tx_count, txq.size()); end
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_set: got %0h want 1", bus.proto_err); end
    if (txq.size() == int'(DEPTH)) begin
      bus.tx_ready = 1'b1; tick(); bus.tx_ready = 1'b0;
      void'(txq.pop_front());
    end
    d = W'($urandom);
    core_write(d, ok);
    txq.push_back(d);
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_sticky: got %0h want 1", bus.proto_err); end
  endtask

  task automatic test_mid_reset();
    rx_push(W'($urandom));
    bus.io_read = 1'b1;
    tick();
    checks++; if (bus.ioack !== 1'b1) begin errors++; $display("FAIL midrst_ack_cycle: ioack got %0h want 1", bus.ioack); end
    reset = 1'b0;
    tick();
    checks++; if (bus.ioack !== 1'b0) begin errors++; $display("FAIL midrst_ioack: got %0h want 0", bus.ioack); end
    checks++; if (bus.rx_count !== '0 || bus.tx_count !== '0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_fifos: rx=%0d tx=%0d tx_valid=%0h want 0 0 0", bus.rx_count, bus.tx_count, bus.tx_valid); end
    bus.io_read = 1'b0;
    reset = 1'b1;
    tick();
    rxq.delete();
    txq.delete();
    checks++; if (bus.rx_ready !== 1'b1 || bus.proto_err !== 1'b0 || bus.ioack !== 1'b0) begin errors++; $display("FAIL midrst_after: rx_ready=%0h proto_err=%0h ioack=%0h want 1 0 0", bus.rx_ready, bus.proto_err, bus.ioack); end
  endtask

  initial begin
    bus.io_read    = 1'b0;
    bus.io_write   = 1'b0;
    bus.io_bus_out = '0;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.tx_ready   = 1'b0;
    test_reset();
    test_stalled_read();
    test_held_write();
    test_full_boundary();
    test_back_to_back();
    test_random();
    test_proto_err();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sextium_io_bridge.md
# sextium_io_bridge

Synthesizable I/O peripheral on the Sextium III core's I/O port, replacing the behavioural I/O model used in simulation. It terminates the core's `io_read`/`io_write`/`ioack` handshake and buffers words in two synchronous FIFOs. The RX FIFO is filled from an external valid/ready input stream and drained by core reads. The TX FIFO is filled by core writes and drained to an external valid/ready output stream.

## Interface
Parameters:
- `WIDTH`, 16, I/O word width; must match core `io_bus_*`.
- `DEPTH_LOG2`, 4, log2 of each FIFO depth (16 entries).

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset: sampled on the `clock` edge, state cleared while low.
- `io_read`  in  1  core read request; held high until `ioack` is seen.
- `io_write`  in  1  core write request; held high until `ioack` is seen.
- `io_bus_out`  in  WIDTH  core write data; valid while `io_write` is high.
- `io_bus_in`  out  WIDTH  read data to core.
- `ioack`  out  1  one-cycle transaction-complete pulse.
- `rx_data`  in  WIDTH  external input word.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  RX FIFO can accept a word.
- `tx_data`  out  WIDTH  head of TX FIFO.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  consumer takes `tx_data`.
- `rx_count`, `tx_count`  out  DEPTH_LOG2+1  FIFO occupancy.
- `proto_err`  out  1  sticky; set when `io_read` and `io_write` are high in the same cycle.

## Operation
- **RX push:** when `rx_valid && rx_ready`. `rx_ready = !rx_full` (no push on full, even if a pop happens in the same cycle).
- **TX pop:** when `tx_valid && tx_ready`. `tx_valid = !tx_empty`. `tx_data` is the show-ahead head.
- **Handshake FSM states:**
  - `IDLE`:
    - `io_read` and RX FIFO non-empty: pop, latch the head into `io_bus_in`, go to `ACK`.
    - `io_write` and TX FIFO not full: push `io_bus_out`, go to `ACK`.
    - Otherwise stay in `IDLE` (stall, no ack).
  - `ACK`: `ioack=1` for exactly this cycle, then go to `RELEASE`.
  - `RELEASE`: wait until `io_read` and `io_write` are both low, then go to `IDLE`. This prevents a held request from completing twice.
- **Read and write both high in `IDLE`:** the read is served, the write is ignored, and `proto_err` is set. `proto_err` clears only on reset.
- **`io_bus_in`** holds the last read word until the next read completes.
- **Occupancy:**
  - Counts saturate at 0 and 2^DEPTH_LOG2 by construction; there is no overflow or underflow.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- **Reset values** (while `reset` low, and after the first edge with `reset` high): FSM = `IDLE`, both FIFOs empty, `io_bus_in=0`, `ioack=0`, `tx_valid=0`, `rx_ready=0` while in reset and 1 afterwards, counts 0, `proto_err=0`.
- **Reset during a transaction:** the FSM returns to `IDLE` and no `ioack` is issued. Words in the FIFOs are discarded.

## Timing
- **Read latency:** request sampled in `IDLE` at edge N with RX non-empty → `ioack` and valid `io_bus_in` at N+1 → `RELEASE` from N+2.
- **Write latency:** same as read. The word is visible on `tx_data`/`tx_valid` from N+1.
- **No bypass:** a word pushed at edge N is poppable from edge N+1. An RX push into an empty FIFO therefore serves a stalled read with `ioack` at N+2.
- **Minimum spacing:** 3 cycles between core transactions (`IDLE`, `ACK`, `RELEASE`, with the request dropped in `RELEASE`).
- All outputs are registered except `rx_ready`, `tx_valid` and `tx_data`, which are decoded from registered pointers and counts.

## Structure
- **Package `sextium_io_pkg`:** `WIDTH` default, FSM state enum (`IDLE`, `ACK`, `RELEASE`).
- **Sub-module `sextium_sync_fifo`:**
  - Parameters: `WIDTH`, `DEPTH_LOG2`.
  - Ports: push/pop, full/empty, count, show-ahead head.
  - Instantiated twice (RX, TX).
- The top level contains only the FSM, the `io_bus_in` register and `proto_err`.

## Test plan
- **Reset:** hold `reset` low 3 cycles with `rx_valid=1` → all outputs at reset values, no push. Release `reset` → `rx_ready=1` on the next cycle.
- **Stalled read:** `io_read=1` with RX empty for 5 cycles → `ioack` stays 0. Then push 0xBEEF → `ioack` 2 cycles after the push, `io_bus_in=0xBEEF`, `rx_count=0`.
- **Held write:** write 0x1234 with `io_write` held 6 cycles → exactly one `ioack`, `tx_count=1`, `tx_data=0x1234`. Pulse `tx_ready` → `tx_valid=0`.
- **Full boundary:** push 16 words 0..15 → `rx_ready=0` and `rx_count=16`; a 17th `rx_valid` is not accepted. 16 core reads return 0..15 in order, with pointer wrap; a further push then succeeds.
- **Protocol error:** `io_read` and `io_write` high together with RX holding 0x00AA → read acked with 0x00AA, TX unchanged, `proto_err=1` until reset.
- **Mid-transaction reset:** assert `reset` low in the `ACK` cycle → `ioack` 0 on the following edge, FIFOs empty.
